// File: rtl/idex_pipe_stage.sv
// ============================================================================
// idex_pipe_stage
// ----------------------------------------------------------------------------
// Parametrised ID->EX pipeline register. It latches the decode-stage bundle
// (control vector, NUM_SRC operand lanes, immediate, hazard descriptor, branch
// delay slot flag and restart PC) into the execute stage one cycle later.
//
// On top of a plain latch it provides:
//   - an explicit valid bit, with bubble insertion whenever decode has nothing
//     real to hand over (stalled, squashed, or not valid);
//   - in-place refresh of held operands from the forwarding network while
//     execute is stalled, so results that arrive late are not lost.
//
// Priority per rising edge, highest first:
//   reset > ex_flush > ex_stall (hold) > bubble > advance
//
// Stage state is encoded directly in {ex_valid, ex_held}:
//   EMPTY = 2'b00, RUN = 2'b10, HOLD = 2'b11
//
// Optional feature (compile-time macro PIPE_PERF_EN):
//   when defined, stall_cnt / bubble_cnt are saturating 32-bit performance
//   counters cleared by reset or perf_clr; when undefined they read 0 and
//   perf_clr is ignored.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   id_stall       in   decode stalled -> bubble into EX
//   id_flush       in   decode squashed -> bubble into EX
//   ex_stall       in   execute stalled -> stage holds its contents
//   ex_flush       in   execute squashed -> kill current EX contents
//   id_valid       in   decode holds a real instruction
//   id_ctrl        in   [CTRL_W]             control vector
//   id_src_addr    in   [NUM_SRC*REG_ADDR_W] source register numbers, lane 0 in LSBs
//   id_src_data    in   [NUM_SRC*DATA_W]     source operand values, lane 0 in LSBs
//   id_imm         in   [DATA_W]             extended immediate
//   id_hazards     in   [HAZ_W]              hazard descriptor
//   id_is_bds      in   branch delay slot flag
//   id_restart_pc  in   [PC_W]               restart PC for exceptions
//   fwd_upd        in   [NUM_SRC]            per-lane refresh strobe (only while held)
//   fwd_data       in   [NUM_SRC*DATA_W]     refresh values
//   perf_clr       in   clear performance counters
//   ex_valid       out  EX holds a real instruction
//   ex_ctrl .. ex_restart_pc  out  registered copies of the ID bundle
//   ex_held        out  stage was held with valid content on the previous edge
//   stall_cnt      out  [32] cycles held while valid
//   bubble_cnt     out  [32] bubbles inserted
// ============================================================================
module idex_pipe_stage #(
    parameter int CTRL_W     = 24,
    parameter int DATA_W     = 32,
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int HAZ_W      = 8,
    parameter int PC_W       = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          id_stall,
    input  logic                          id_flush,
    input  logic                          ex_stall,
    input  logic                          ex_flush,
    input  logic                          id_valid,
    input  logic [CTRL_W-1:0]             id_ctrl,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC*DATA_W-1:0]     id_src_data,
    input  logic [DATA_W-1:0]             id_imm,
    input  logic [HAZ_W-1:0]              id_hazards,
    input  logic                          id_is_bds,
    input  logic [PC_W-1:0]               id_restart_pc,
    input  logic [NUM_SRC-1:0]            fwd_upd,
    input  logic [NUM_SRC*DATA_W-1:0]     fwd_data,
    input  logic                          perf_clr,
    output logic                          ex_valid,
    output logic [CTRL_W-1:0]             ex_ctrl,
    output logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_addr,
    output logic [NUM_SRC*DATA_W-1:0]     ex_src_data,
    output logic [DATA_W-1:0]             ex_imm,
    output logic [HAZ_W-1:0]              ex_hazards,
    output logic                          ex_is_bds,
    output logic [PC_W-1:0]               ex_restart_pc,
    output logic                          ex_held,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   bubble_cnt
);

    localparam int ADDR_VW = NUM_SRC * REG_ADDR_W;
    localparam int DATA_VW = NUM_SRC * DATA_W;

    // State encoding doubles as the {ex_valid, ex_held} output pair, so the
    // status outputs come straight from flops.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_RUN   = 2'b10,
        ST_HOLD  = 2'b11
    } stage_state_e;

    // Action taken on the coming edge, resolved once in priority order and
    // shared by the datapath and the performance counters.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_ADVANCE
    } stage_act_e;

    stage_state_e         state_q;
    stage_act_e           act;
    logic                 bubble;

    logic [CTRL_W-1:0]    ctrl_q;
    logic [ADDR_VW-1:0]   src_addr_q;
    logic [DATA_VW-1:0]   src_data_q;
    logic [DATA_VW-1:0]   src_data_refreshed;
    logic [DATA_W-1:0]    imm_q;
    logic [HAZ_W-1:0]     hazards_q;
    logic                 is_bds_q;
    logic [PC_W-1:0]      restart_pc_q;

    // ------------------------------------------------------------------------
    // Edge action
    // ------------------------------------------------------------------------
    assign bubble = id_stall | id_flush | ~id_valid;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        act = ACT_ADVANCE;
        if (reset) begin
            act = ACT_RESET;
        end else if (ex_flush) begin
            act = ACT_FLUSH;
        end else if (ex_stall) begin
            act = ACT_HOLD;
        end else if (bubble) begin
            act = ACT_BUBBLE;
        end
    end

    // ------------------------------------------------------------------------
    // Operand refresh while held: only lanes of a real instruction are
    // updated; strobes on an empty stage carry nothing worth keeping.
    // ------------------------------------------------------------------------
    always_comb begin
        src_data_refreshed = src_data_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fwd_upd[i] && state_q != ST_EMPTY) begin
                src_data_refreshed[i*DATA_W +: DATA_W] = fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------------
    // NOTE: reset is synchronous and sampled inside the clocked block; every
    // field is cleared because all outputs must read 0 after reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of statement order.
        case (act)
            ACT_RESET: begin
                state_q      <= ST_EMPTY;
                ctrl_q       <= '0;
                src_addr_q   <= '0;
                src_data_q   <= '0;
                imm_q        <= '0;
                hazards_q    <= '0;
                is_bds_q     <= 1'b0;
                restart_pc_q <= '0;
            end

            // Kill the instruction but keep data, immediate, BDS flag and PC:
            // the exception logic still needs the PC of the squashed slot.
            ACT_FLUSH: begin
                state_q    <= ST_EMPTY;
                ctrl_q     <= '0;
                src_addr_q <= '0;
                hazards_q  <= '0;
            end

            // Hold everything except late-forwarded operands. An empty stage
            // stays empty; a valid one reports held on the next cycle.
            ACT_HOLD: begin
                state_q    <= (state_q == ST_EMPTY) ? ST_EMPTY : ST_HOLD;
                src_data_q <= src_data_refreshed;
            end

            // Bubble: zero control and addresses so no stale register number
            // can match in the forwarding comparators, but carry BDS flag and
            // PC so an exception raised against the bubble reports correctly.
            ACT_BUBBLE: begin
                state_q      <= ST_EMPTY;
                ctrl_q       <= '0;
                src_addr_q   <= '0;
                hazards_q    <= '0;
                src_data_q   <= id_src_data;
                imm_q        <= id_imm;
                is_bds_q     <= id_is_bds;
                restart_pc_q <= id_restart_pc;
            end

            default: begin // ACT_ADVANCE
                state_q      <= ST_RUN;
                ctrl_q       <= id_ctrl;
                src_addr_q   <= id_src_addr;
                src_data_q   <= id_src_data;
                imm_q        <= id_imm;
                hazards_q    <= id_hazards;
                is_bds_q     <= id_is_bds;
                restart_pc_q <= id_restart_pc;
            end
        endcase
    end

    assign ex_valid      = state_q[1];
    assign ex_held       = state_q[0];
    assign ex_ctrl       = ctrl_q;
    assign ex_src_addr   = src_addr_q;
    assign ex_src_data   = src_data_q;
    assign ex_imm        = imm_q;
    assign ex_hazards    = hazards_q;
    assign ex_is_bds     = is_bds_q;
    assign ex_restart_pc = restart_pc_q;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic        stall_evt;
    logic        bubble_evt;

    // A hold only counts when it is holding a real instruction.
    assign stall_evt  = (act == ACT_HOLD) && (state_q != ST_EMPTY);
    assign bubble_evt = (act == ACT_BUBBLE);

    // Clear wins over increment; counters stick at all-ones instead of
    // wrapping so a long run never reads as a small count.
    always_ff @(posedge clock) begin
        if (reset || perf_clr) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall_evt && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bubble_evt && bubble_cnt_q != '1) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr;
    assign stall_cnt       = '0;
    assign bubble_cnt      = '0;
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// ============================================================================
// tb_idex_pipe_stage
// ----------------------------------------------------------------------------
// Directed testbench for idex_pipe_stage with default parameters (2 lanes).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled 1 time unit after the following rising edge.
// Counter expectations follow PIPE_PERF_EN: real counts when defined, zero
// otherwise.
// ============================================================================
module tb_idex_pipe_stage;

    localparam int CTRL_W     = 24;
    localparam int DATA_W     = 32;
    localparam int NUM_SRC    = 2;
    localparam int REG_ADDR_W = 5;
    localparam int HAZ_W      = 8;
    localparam int PC_W       = 32;

`ifdef PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                          clock;
    logic                          reset;
    logic                          id_stall;
    logic                          id_flush;
    logic                          ex_stall;
    logic                          ex_flush;
    logic                          id_valid;
    logic [CTRL_W-1:0]             id_ctrl;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr;
    logic [NUM_SRC*DATA_W-1:0]     id_src_data;
    logic [DATA_W-1:0]             id_imm;
    logic [HAZ_W-1:0]              id_hazards;
    logic                          id_is_bds;
    logic [PC_W-1:0]               id_restart_pc;
    logic [NUM_SRC-1:0]            fwd_upd;
    logic [NUM_SRC*DATA_W-1:0]     fwd_data;
    logic                          perf_clr;
    logic                          ex_valid;
    logic [CTRL_W-1:0]             ex_ctrl;
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_addr;
    logic [NUM_SRC*DATA_W-1:0]     ex_src_data;
    logic [DATA_W-1:0]             ex_imm;
    logic [HAZ_W-1:0]              ex_hazards;
    logic                          ex_is_bds;
    logic [PC_W-1:0]               ex_restart_pc;
    logic                          ex_held;
    logic [31:0]                   stall_cnt;
    logic [31:0]                   bubble_cnt;

    int checks = 0;
    int errors = 0;

    idex_pipe_stage #(
        .CTRL_W    (CTRL_W),
        .DATA_W    (DATA_W),
        .NUM_SRC   (NUM_SRC),
        .REG_ADDR_W(REG_ADDR_W),
        .HAZ_W     (HAZ_W),
        .PC_W      (PC_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .id_stall     (id_stall),
        .id_flush     (id_flush),
        .ex_stall     (ex_stall),
        .ex_flush     (ex_flush),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_src_addr  (id_src_addr),
        .id_src_data  (id_src_data),
        .id_imm       (id_imm),
        .id_hazards   (id_hazards),
        .id_is_bds    (id_is_bds),
        .id_restart_pc(id_restart_pc),
        .fwd_upd      (fwd_upd),
        .fwd_data     (fwd_data),
        .perf_clr     (perf_clr),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_src_addr  (ex_src_addr),
        .ex_src_data  (ex_src_data),
        .ex_imm       (ex_imm),
        .ex_hazards   (ex_hazards),
        .ex_is_bds    (ex_is_bds),
        .ex_restart_pc(ex_restart_pc),
        .ex_held      (ex_held),
        .stall_cnt    (stall_cnt),
        .bubble_cnt   (bubble_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle before sampling or re-driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        id_stall      = 1'b0;
        id_flush      = 1'b0;
        ex_stall      = 1'b0;
        ex_flush      = 1'b0;
        id_valid      = 1'b0;
        id_ctrl       = '0;
        id_src_addr   = '0;
        id_src_data   = '0;
        id_imm        = '0;
        id_hazards    = '0;
        id_is_bds     = 1'b0;
        id_restart_pc = '0;
        fwd_upd       = '0;
        fwd_data      = '0;
        perf_clr      = 1'b0;

        // ---- 1. reset for two cycles, then advance --------------------------
        tick();
        tick();
        check("rst_valid",  ex_valid,      0);
        check("rst_held",   ex_held,       0);
        check("rst_ctrl",   ex_ctrl,       0);
        check("rst_addr",   ex_src_addr,   0);
        check("rst_data",   ex_src_data,   0);
        check("rst_imm",    ex_imm,        0);
        check("rst_haz",    ex_hazards,    0);
        check("rst_bds",    ex_is_bds,     0);
        check("rst_pc",     ex_restart_pc, 0);
        check("rst_scnt",   stall_cnt,     0);
        check("rst_bcnt",   bubble_cnt,    0);

        reset         = 1'b0;
        id_valid      = 1'b1;
        id_ctrl       = 24'h00A5A5;
        id_src_addr   = {5'd3, 5'd7};
        id_src_data   = {32'h2222_2222, 32'h1111_1111};
        id_imm        = 32'h0000_0010;
        id_hazards    = 8'h5A;
        id_is_bds     = 1'b0;
        id_restart_pc = 32'h8000_0180;
        tick();
        check("adv_valid", ex_valid,      1);
        check("adv_held",  ex_held,       0);
        check("adv_ctrl",  ex_ctrl,       24'h00A5A5);
        check("adv_addr",  ex_src_addr,   10'h067);
        check("adv_data",  ex_src_data,   64'h2222_2222_1111_1111);
        check("adv_imm",   ex_imm,        32'h0000_0010);
        check("adv_haz",   ex_hazards,    8'h5A);
        check("adv_bds",   ex_is_bds,     0);
        check("adv_pc",    ex_restart_pc, 32'h8000_0180);

        // ---- 2. hold with refresh (ID changes meanwhile, must be ignored) ---
        ex_stall      = 1'b1;
        id_ctrl       = 24'h123456;
        id_src_data   = {32'h7777_7777, 32'h6666_6666};
        id_restart_pc = 32'h8000_0200;
        tick();
        check("hold1_held", ex_held,     1);
        check("hold1_ctrl", ex_ctrl,     24'h00A5A5);
        check("hold1_data", ex_src_data, 64'h2222_2222_1111_1111);
        fwd_upd  = 2'b10;
        fwd_data = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        tick();
        check("hold2_data", ex_src_data, 64'hDEAD_BEEF_1111_1111);
        check("hold2_held", ex_held,     1);
        fwd_upd = 2'b00;
        tick();
        check("hold3_ctrl",  ex_ctrl,       24'h00A5A5);
        check("hold3_data",  ex_src_data,   64'hDEAD_BEEF_1111_1111);
        check("hold3_valid", ex_valid,      1);
        check("hold3_held",  ex_held,       1);
        check("hold3_pc",    ex_restart_pc, 32'h8000_0180);

        // ---- 3. bubble keeps PC and BDS flag ---------------------------------
        ex_stall      = 1'b0;
        id_stall      = 1'b1;
        id_is_bds     = 1'b1;
        id_restart_pc = 32'hBFC0_0010;
        id_imm        = 32'h0000_0ABC;
        id_src_data   = {32'h3333_3333, 32'h4444_4444};
        tick();
        check("bub_valid", ex_valid,      0);
        check("bub_held",  ex_held,       0);
        check("bub_ctrl",  ex_ctrl,       0);
        check("bub_addr",  ex_src_addr,   0);
        check("bub_haz",   ex_hazards,    0);
        check("bub_bds",   ex_is_bds,     1);
        check("bub_pc",    ex_restart_pc, 32'hBFC0_0010);
        check("bub_imm",   ex_imm,        32'h0000_0ABC);

        // Refresh strobe on an empty stage is ignored.
        id_stall = 1'b0;
        ex_stall = 1'b1;
        fwd_upd  = 2'b11;
        fwd_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tick();
        check("empty_fwd_data",  ex_src_data, 64'h3333_3333_4444_4444);
        check("empty_fwd_valid", ex_valid,    0);
        check("empty_fwd_held",  ex_held,     0);

        // Advance again (EMPTY -> RUN).
        ex_stall      = 1'b0;
        fwd_upd       = 2'b00;
        id_is_bds     = 1'b0;
        id_ctrl       = 24'h0F0F0F;
        id_src_addr   = {5'd31, 5'd1};
        id_src_data   = {32'hAAAA_0001, 32'h5555_0000};
        id_hazards    = 8'hC3;
        id_restart_pc = 32'h8000_1000;
        tick();
        check("adv2_valid", ex_valid,    1);
        check("adv2_addr",  ex_src_addr, 10'h3E1);
        check("adv2_haz",   ex_hazards,  8'hC3);

        // ---- 4. flush beats stall and discards the refresh strobe -----------
        ex_stall      = 1'b1;
        ex_flush      = 1'b1;
        fwd_upd       = 2'b01;
        fwd_data      = {32'h8888_8888, 32'h9999_9999};
        id_restart_pc = 32'h8000_2000;
        tick();
        check("fl_valid", ex_valid,      0);
        check("fl_held",  ex_held,       0);
        check("fl_ctrl",  ex_ctrl,       0);
        check("fl_addr",  ex_src_addr,   0);
        check("fl_haz",   ex_hazards,    0);
        check("fl_data",  ex_src_data,   64'hAAAA_0001_5555_0000);
        check("fl_pc",    ex_restart_pc, 32'h8000_1000);

        // !id_valid is a bubble too.
        ex_stall = 1'b0;
        ex_flush = 1'b0;
        fwd_upd  = 2'b00;
        id_valid = 1'b0;
        tick();
        check("nv_valid", ex_valid,      0);
        check("nv_pc",    ex_restart_pc, 32'h8000_2000);

        // ---- 5. reset in HOLD ------------------------------------------------
        id_valid = 1'b1;
        tick();
        ex_stall = 1'b1;
        tick();
        check("pre_rst_held", ex_held, 1);
        reset = 1'b1;
        tick();
        check("mrst_valid", ex_valid,      0);
        check("mrst_held",  ex_held,       0);
        check("mrst_ctrl",  ex_ctrl,       0);
        check("mrst_data",  ex_src_data,   0);
        check("mrst_pc",    ex_restart_pc, 0);
        check("mrst_imm",   ex_imm,        0);
        reset    = 1'b0;
        ex_stall = 1'b0;
        tick();
        check("post_rst_valid", ex_valid, 1);
        check("post_rst_held",  ex_held,  0);
        check("post_rst_ctrl",  ex_ctrl,  24'h0F0F0F);

        // id_flush inserts a bubble.
        id_flush = 1'b1;
        tick();
        check("idfl_valid", ex_valid, 0);
        id_flush = 1'b0;

        // ---- 6. performance counters from a fresh reset ----------------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();                       // advance: no count
        ex_stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ex_stall = 1'b0;
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        id_stall = 1'b0;
        check("cnt_stall",  stall_cnt,  PERF ? 32'd5 : 32'd0);
        check("cnt_bubble", bubble_cnt, PERF ? 32'd3 : 32'd0);

        tick();                       // advance: valid again
        ex_stall = 1'b1;
        perf_clr = 1'b1;
        tick();
        check("clr_stall",  stall_cnt,  0);
        check("clr_bubble", bubble_cnt, 0);
        perf_clr = 1'b0;
        tick();
        check("after_clr_stall", stall_cnt, PERF ? 32'd1 : 32'd0);
        ex_stall = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
